// File: rtl/func_pkg.sv
// Shared definitions for the 2-input function probe: FSM state encoding and
// truth-table codes (bit3 = f(0,0), bit2 = f(0,1), bit1 = f(1,0), bit0 = f(1,1)).
package func_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] FN_ZERO = 4'b0000;
   localparam logic [3:0] FN_AND  = 4'b0001;
   localparam logic [3:0] FN_X    = 4'b0011;
   localparam logic [3:0] FN_Y    = 4'b0101;
   localparam logic [3:0] FN_XOR  = 4'b0110;
   localparam logic [3:0] FN_OR   = 4'b0111;
   localparam logic [3:0] FN_NOR  = 4'b1000;
   localparam logic [3:0] FN_XNOR = 4'b1001;
   localparam logic [3:0] FN_NAND = 4'b1110;
   localparam logic [3:0] FN_ONE  = 4'b1111;

endpackage

// File: rtl/func_probe.sv
// Sweeps the four (x,y) input vectors through an external 2-input block,
// waits SETTLE_CYCLES per vector, and rebuilds its truth-table code in sel_out.
module func_probe
   import func_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] exp_sel,
   input  logic       z,
   output logic       probe_x,
   output logic       probe_y,
   output logic [3:0] sel_out,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic       match
);

   localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

   logic [1:0] state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       valid_q, valid_d;
   logic       match_q, match_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      match_d = match_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
               valid_d = 1'b0;
               match_d = 1'b0;
               idx_d   = 2'd0;
               cnt_d   = 4'd0;
            end
         end
         ST_RUN: begin
            // Abort wins over a capture landing on the same edge.
            if (abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b0;
               sel_d   = 4'd0;
               idx_d   = 2'd0;
               cnt_d   = 4'd0;
            end else if (cnt_q == SETTLE_LIM) begin
               sel_d[2'd3 - idx_q] = z;
               cnt_d = 4'd0;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            match_d = (sel_q == exp_sel);
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         sel_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         match_q <= match_d;
      end
   end

   // Probes are gated by state so they fall to 0,0 the moment reset lands.
   assign probe_x = (state_q == ST_RUN) & idx_q[1];
   assign probe_y = (state_q == ST_RUN) & idx_q[0];
   assign sel_out = sel_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign valid   = valid_q;
   assign match   = match_q;

endmodule

// File: tb/tb_func_probe.sv
// Scoreboard bench for func_probe: two instances (settle 2 and settle 0) each
// driving a behavioural function block that can optionally lag by two cycles.
module tb_func_probe;
   import func_pkg::*;

   typedef struct {
      logic [3:0] sel;
      logic       match;
      int         doneAt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       startA, start0, abort;
   logic [3:0] expSel;
   logic       zA, z0;
   logic       pxA, pyA, px0, py0;
   logic [3:0] selA, sel0;
   logic       busyA, doneA, validA, matchA;
   logic       busy0, done0, valid0, match0;

   logic [3:0] fnCode = 4'd0;
   logic       lagMode = 1'b0;
   logic [1:0] pipeA = 2'd0;
   logic [1:0] pipe0 = 2'd0;

   int   cyc = 0;
   int   passCount = 0;
   int   checkCount = 0;
   int   tStart;
   exp_t qA[$];
   exp_t q0[$];
   exp_t eA, e0;

   always #5 clk = ~clk;

   func_probe #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(startA), .abort(abort), .exp_sel(expSel),
      .z(zA), .probe_x(pxA), .probe_y(pyA), .sel_out(selA), .busy(busyA),
      .done(doneA), .valid(validA), .match(matchA)
   );

   func_probe #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .exp_sel(expSel),
      .z(z0), .probe_x(px0), .probe_y(py0), .sel_out(sel0), .busy(busy0),
      .done(done0), .valid(valid0), .match(match0)
   );

   function automatic logic evalFn(logic [3:0] code, logic x, logic y);
      return code[2'd3 - {x, y}];
   endfunction

   // Behavioural block under probe, optionally delayed by two clock stages.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      pipeA <= {pipeA[0], evalFn(fnCode, pxA, pyA)};
      pipe0 <= {pipe0[0], evalFn(fnCode, px0, py0)};
   end

   assign zA = lagMode ? pipeA[1] : evalFn(fnCode, pxA, pyA);
   assign z0 = lagMode ? pipe0[1] : evalFn(fnCode, px0, py0);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Set the model, let it settle, pulse start, and queue the expected result.
   task automatic applyStimulus(input bit useZero, input logic [3:0] code, input logic lag,
                                input logic [3:0] exp, input logic [3:0] wantSel,
                                input logic wantMatch, input bit expectDone);
      exp_t e;
      @(negedge clk);
      fnCode  = code;
      lagMode = lag;
      expSel  = exp;
      repeat (3) @(negedge clk);
      if (useZero) start0 = 1'b1;
      else startA = 1'b1;
      @(posedge clk);
      #1 tStart = cyc;
      if (expectDone) begin
         e.sel    = wantSel;
         e.match  = wantMatch;
         e.doneAt = tStart + (useZero ? 5 : 13);
         if (useZero) q0.push_back(e);
         else qA.push_back(e);
      end
      @(negedge clk);
      startA = 1'b0;
      start0 = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((qA.size() != 0 || q0.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drainTimeout", qA.size() + q0.size(), 0);
   endtask

   // Monitors: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (doneA === 1'b1) begin
         if (qA.size() == 0) checkOutput("unexpectedDoneA", doneA, 0);
         else begin
            eA = qA.pop_front();
            checkOutput("selA", selA, eA.sel);
            checkOutput("matchA", matchA, eA.match);
            checkOutput("validA", validA, 1);
            checkOutput("busyA", busyA, 0);
            checkOutput("doneCycleA", cyc, eA.doneAt);
         end
      end
      if (done0 === 1'b1) begin
         if (q0.size() == 0) checkOutput("unexpectedDone0", done0, 0);
         else begin
            e0 = q0.pop_front();
            checkOutput("sel0", sel0, e0.sel);
            checkOutput("match0", match0, e0.match);
            checkOutput("valid0", valid0, 1);
            checkOutput("doneCycle0", cyc, e0.doneAt);
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      startA = 1'b0;
      start0 = 1'b0;
      abort  = 1'b0;
      expSel = 4'd0;
      #1;
      checkOutput("resetOutsA", {pxA, pyA, selA, busyA, doneA, validA, matchA}, 0);
      checkOutput("resetOuts0", {px0, py0, sel0, busy0, done0, valid0, match0}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // AND sweep with probe stepping every three cycles.
      applyStimulus(0, FN_AND, 1'b0, FN_AND, 4'b0001, 1'b1, 1);
      checkOutput("busyRun", busyA, 1);
      checkOutput("validCleared", validA, 0);
      for (int k = 0; k < 4; k++) begin
         if (k != 0) repeat (3) @(negedge clk);
         checkOutput($sformatf("probeStep%0d", k), {pxA, pyA}, k);
      end
      waitDrain();

      // XOR sweep with a second start at T+5 that must be ignored.
      applyStimulus(0, FN_XOR, 1'b0, FN_XOR, 4'b0110, 1'b1, 1);
      repeat (4) @(negedge clk);
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      waitDrain();
      repeat (5) @(negedge clk);
      checkOutput("holdSel", selA, 4'b0110);
      checkOutput("holdValidMatch", {validA, matchA}, 2'b11);

      applyStimulus(0, FN_ONE, 1'b0, FN_NAND, 4'b1111, 1'b0, 1);
      waitDrain();

      // Lagging block: settle 2 hides the lag, settle 0 reads stale values.
      applyStimulus(0, FN_NOR, 1'b1, FN_NOR, 4'b1000, 1'b1, 1);
      waitDrain();
      applyStimulus(1, FN_NOR, 1'b1, FN_NOR, 4'b1110, 1'b0, 1);
      waitDrain();
      applyStimulus(1, FN_AND, 1'b0, FN_AND, 4'b0001, 1'b1, 1);
      waitDrain();

      // Abort seen at edge T+8 with two bits already captured.
      applyStimulus(0, FN_ONE, 1'b0, FN_ONE, 4'b1111, 1'b1, 0);
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abortOuts", {busyA, validA, doneA, selA}, 0);
      @(negedge clk);
      abort = 1'b0;
      repeat (20) @(negedge clk);

      // Asynchronous reset while idx = 2.
      applyStimulus(0, FN_ONE, 1'b0, FN_ONE, 4'b1111, 1'b1, 0);
      repeat (7) @(negedge clk);
      checkOutput("preResetProbe", {pxA, pyA}, 2'b10);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetOuts", {pxA, pyA, selA, busyA, doneA, validA, matchA}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("postResetIdle", {pxA, pyA, busyA, validA}, 0);
      repeat (20) @(negedge clk);

      checkOutput("queuesEmpty", qA.size() + q0.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/func_probe.md
FUNC_PROBE -- requirements
Module: func_probe

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of wait cycles after each probe vector change before z is sampled (legal range 0..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a probe sweep; sampled in IDLE only.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of a sweep in progress.
REQ-006 SHALL have port exp_sel, input, 4 bits: expected function code, compared at completion.
REQ-007 SHALL have port z, input, 1 bit: output of the 2-input function block under probe.
REQ-008 SHALL have port probe_x, output, 1 bit: x stimulus to the block under probe.
REQ-009 SHALL have port probe_y, output, 1 bit: y stimulus to the block under probe.
REQ-010 SHALL have port sel_out, output, 4 bits: recovered function code.
REQ-011 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port valid, output, 1 bit: sel_out holds a completed result.
REQ-014 SHALL have port match, output, 1 bit: sel_out equals exp_sel; qualified by valid.

Function
REQ-015 SHALL use the truth-table encoding: sel bit3 = z at (x,y)=(0,0); bit2 = (0,1); bit1 = (1,0); bit0 = (1,1).
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1 at edge T, enter RUN, clear valid, set busy=1, vector index idx=0, and settle count cnt=0.
REQ-018 SHALL drive (probe_x, probe_y) = (idx[1], idx[0]) throughout RUN, and 0,0 outside RUN.
REQ-019 SHALL increment cnt each RUN cycle; at the edge where cnt==SETTLE_CYCLES, it SHALL capture z into sel_out bit (3-idx), clear cnt, and advance idx.
REQ-020 SHALL move from RUN to DONE on the capture edge for idx=3.
REQ-021 SHALL, in DONE (one cycle), assert done=1, busy=0, valid=1, and match=(sel_out==exp_sel) registered, then return to IDLE.
REQ-022 SHALL assert done exactly 1+4*(SETTLE_CYCLES+1) cycles after the start edge (13 for the default).
REQ-023 SHALL ignore start while in RUN or DONE; a new start in IDLE re-runs the sweep.
REQ-024 SHALL hold sel_out, valid, and match stable in IDLE until the next accepted start.
REQ-025 SHALL, on abort=1 in RUN, go to IDLE next edge with busy=0, valid=0, done=0, and sel_out=0; abort has priority over capture in the same cycle.
REQ-026 SHALL treat abort in IDLE or DONE as no effect.
REQ-027 SHALL, when SETTLE_CYCLES=0, capture on every RUN cycle (4-cycle sweep).

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE and idx, cnt, sel_out, probe_x, probe_y, busy, done, valid, and match to 0, independent of clk.
REQ-029 SHALL, on reset mid-sweep, discard any partial result; a sweep SHALL not resume.

Structure
REQ-030 SHALL place the state encoding and named function-code constants (ZERO=0000, AND=0001, X=0011, Y=0101, XOR=0110, OR=0111, NOR=1000, XNOR=1001, NAND=1110, ONE=1111) in shared package func_pkg.
REQ-031 SHALL remain a single module; no sub-module is required.

Verification
REQ-032 SHALL verify: AND model, SETTLE_CYCLES=2, start at T -> probes step 00,01,10,11 every 3 cycles; done at T+13; sel_out=0001.
REQ-033 SHALL verify: XOR model, exp_sel=0110 -> sel_out=0110, match=1; constant-1 model, exp_sel=1110 -> sel_out=1111, match=0.
REQ-034 SHALL verify: a model whose z lags by 2 cycles -> with SETTLE_CYCLES=2, a NOR model yields sel_out=1000; with SETTLE_CYCLES=0, the NOR model yields an incorrect result.
REQ-035 SHALL verify: start pulsed again at T+5 -> ignored; a single done at T+13.
REQ-036 SHALL verify: rst_n low at idx=2 -> all outputs 0 immediately (asynchronously); after release, IDLE with valid=0.
REQ-037 SHALL verify: abort at T+7 -> busy=0, valid=0 at T+8; no done pulse.
